// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//
// Purpose:
//   Shares one 8x8 signed Booth multiplier core between NREQ requesters.
//   A round-robin arbiter picks one pending request. Its operands are latched
//   and driven to the core together with a held start strobe. The product is
//   captured when the core pulses done. The product is then returned to the
//   granted requester through a valid/ready response channel. A watchdog
//   aborts an operation that never completes. It resets the core for one
//   cycle and returns an error response with a zero product.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising CLK edge where valid and ready are both
//   high. The side driving valid keeps valid and its payload stable until
//   that edge. Requesters may drop req_valid before being granted, which
//   simply withdraws the request. req_ready is a combinational one-hot grant
//   and is only ever high in IDLE. rsp_valid/rsp_id/rsp_product/rsp_err are
//   registered and held until rsp_ready is seen.
//
// Ports:
//   CLK, RSTn          clock (rising edge) and asynchronous active-low reset
//   req_valid[NREQ]    per-requester request
//   req_a/req_b        packed signed operands, requester k at [8k+7:8k]
//   req_ready[NREQ]    one-hot grant (combinational, IDLE only)
//   rsp_valid/ready    response handshake
//   rsp_id             index of the requester being answered
//   rsp_product        signed 16-bit product (0 on abort)
//   rsp_err            response is a watchdog abort
//   mult_start         core Start_Sig, held high for the whole operation
//   mult_a/mult_b      core operands, stable while mult_start is high
//   mult_done          core Done_Sig, one-cycle pulse
//   mult_product       core Product
//   mult_rstn          core reset: RSTn gated low for the single ABORT cycle
//   busy               arbiter is not in IDLE
//   state_dbg          current FSM state encoding (IDLE/RUN/RESP/ABORT)
// ---------------------------------------------------------------------------
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_product,
    output logic              rsp_err,
    output logic              mult_start,
    output logic [7:0]        mult_a,
    output logic [7:0]        mult_b,
    input  logic              mult_done,
    input  logic [15:0]       mult_product,
    output logic              mult_rstn,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RESP  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // Watchdog only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q,       state_d;
    logic [IDW-1:0] rr_ptr_q,      rr_ptr_d;
    logic [IDW-1:0] id_q,          id_d;
    logic           mult_start_q,  mult_start_d;
    logic [7:0]     mult_a_q,      mult_a_d;
    logic [7:0]     mult_b_q,      mult_b_d;
    logic           rsp_valid_q,   rsp_valid_d;
    logic [15:0]    rsp_product_q, rsp_product_d;
    logic           rsp_err_q,     rsp_err_d;
    logic           abort_q,       abort_d;
    logic [WDW-1:0] wdog_q,        wdog_d;

    // ------------------------------------------------------------------
    // Round-robin winner search: start at rr_ptr and walk upward with
    // wrap. cand is one bit wider than an index so rr_ptr + i never
    // overflows before the modulo-NREQ fold.
    // ------------------------------------------------------------------
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // Operand select for the winning requester.
    logic [7:0] win_a;
    logic [7:0] win_b;

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IDW'(k)) begin
                win_a = req_a[8*k +: 8];
                win_b = req_b[8*k +: 8];
            end
        end
    end

    // Grant is combinational so the requester sees acceptance in the same
    // cycle its operands are latched.
    logic [NREQ-1:0] grant;

    always_comb begin
        grant = '0;
        if (state_q == ST_IDLE && found) begin
            grant[winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        mult_start_d  = mult_start_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        abort_d       = abort_q;
        wdog_d        = wdog_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    mult_a_d     = win_a;
                    mult_b_d     = win_b;
                    id_d         = winner;
                    mult_start_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = ST_RUN;
                end
            end

            ST_RUN: begin
                wdog_d = wdog_q + WDW'(1);
                // Done is checked first so a completion in the timeout
                // cycle is still delivered as a good result. Dropping
                // start on this edge lets the core clear done and park.
                if (mult_done) begin
                    rsp_product_d = mult_product;
                    rsp_err_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    mult_start_d  = 1'b0;
                    state_d       = ST_RESP;
                end else if (wdog_q == WD_LAST) begin
                    mult_start_d = 1'b0;
                    abort_d      = 1'b1;
                    state_d      = ST_ABORT;
                end
            end

            ST_ABORT: begin
                // abort_q is high for exactly this cycle, pulsing the core
                // reset; the requester still gets an (error) response.
                abort_d       = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_err_d     = 1'b1;
                rsp_product_d = '0;
                state_d       = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            mult_start_q  <= 1'b0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            abort_q       <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            mult_start_q  <= mult_start_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            abort_q       <= abort_d;
            wdog_q        <= wdog_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign mult_start  = mult_start_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    // Core is held in reset by the system reset and by the abort cycle.
    assign mult_rstn   = RSTn & ~abort_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_arbiter
//
// Directed bench for booth_mult_arbiter. A small behavioural stand-in for the
// Booth core answers mult_start after a fixed latency, or never when
// core_hang is set. Inputs change 2 time units after a rising edge. Outputs
// are checked there, or 1 unit later for combinational ones. Responses are
// scored at the falling edge against a queue of hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_booth_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 19;
    localparam int RW      = 1 + IDW + 16;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic CLK;
    logic RSTn;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_product;
    logic              rsp_err;
    logic              mult_start;
    logic [7:0]        mult_a;
    logic [7:0]        mult_b;
    logic              mult_done;
    logic [15:0]       mult_product;
    logic              mult_rstn;
    logic              busy;
    logic [1:0]        state_dbg;

    booth_mult_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .mult_rstn    (mult_rstn),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ------------------------------------------------------------------
    // Core stand-in: counts LAT cycles of start, pulses done for one cycle.
    // ------------------------------------------------------------------
    logic        core_hang;
    logic        core_done;
    logic [15:0] core_prod;
    int          core_cnt;

    always @(posedge CLK or negedge mult_rstn) begin
        if (!mult_rstn) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_prod <= '0;
        end else if (core_done) begin
            core_done <= 1'b0;
        end else if (mult_start && !core_hang) begin
            if (core_cnt == LAT - 1) begin
                core_done <= 1'b1;
                core_cnt  <= 0;
                core_prod <= $signed({{8{mult_a[7]}}, mult_a}) *
                             $signed({{8{mult_b[7]}}, mult_b});
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    assign mult_done    = core_done;
    assign mult_product = core_prod;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_item;
    logic          multi_hot = 1'b0;

    always @(negedge CLK) begin
        if (RSTn && rsp_valid && rsp_ready) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                check("sb_rsp", 32'({rsp_err, rsp_id, rsp_product}), 32'(exp_item));
            end
        end
        if (RSTn && !$onehot0(req_ready)) begin
            multi_hot = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
        req_valid[k]    = 1'b1;
        req_a[8*k +: 8] = a;
        req_b[8*k +: 8] = b;
    endtask

    task automatic drop_req(input int k);
        req_valid[k] = 1'b0;
    endtask

    task automatic push_exp(input logic err, input logic [IDW-1:0] id, input logic [15:0] p);
        exp_q.push_back({err, id, p});
    endtask

    task automatic wait_rsp(input string tag, input int max);
        for (int i = 0; i < max && !rsp_valid; i++) begin
            tick();
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_grant(input int max, output int n);
        n = 0;
        while (n < max && req_ready == '0) begin
            tick();
            n++;
        end
    endtask

    // One complete operation from a single requester with rsp_ready high.
    task automatic single_op(input string tag, input int k, input logic [7:0] a,
                             input logic [7:0] b, input logic [NREQ-1:0] exp_grant);
        set_req(k, a, b);
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(exp_grant));
        tick();
        drop_req(k);
        #1;
        check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
        check({tag, "_run"}, 32'({busy, mult_start, mult_a, mult_b}), 32'({1'b1, 1'b1, a, b}));
        wait_rsp({tag, "_rsp"}, 80);
        check({tag, "_start_low"}, 32'(mult_start), 32'd0);
        tick();
        check({tag, "_idle"}, 32'({busy, rsp_valid}), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [15:0] t3_prod [4] = '{16'd7, 16'd14, 16'd21, 16'd28};
    int          t3_ids  [5] = '{0, 1, 2, 3, 0};
    int          n;
    int          rstn_lows;

    initial begin
        RSTn      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        core_hang = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_product}), 32'd0);
        check("rst_mult", 32'({mult_start, mult_a, mult_b}), 32'd0);
        check("rst_busy", 32'({busy, state_dbg}), 32'd0);
        check("rst_mult_rstn", 32'(mult_rstn), 32'd0);
        RSTn = 1'b1;
        tick();
        check("mult_rstn_up", 32'(mult_rstn), 32'd1);

        // Single requester: 3 * 5
        rsp_ready = 1'b1;
        push_exp(1'b0, 2'd0, 16'h000F);
        single_op("t1", 0, 8'd3, 8'd5, 4'b0001);

        // Requester 2: -2 * 3 (pointer is at 1, first valid is 2)
        push_exp(1'b0, 2'd2, 16'hFFFA);
        single_op("t2", 2, 8'hFE, 8'h03, 4'b0100);

        // Requester 3: -1 * -1, brings the pointer back to 0
        push_exp(1'b0, 2'd3, 16'h0001);
        single_op("t2b", 3, 8'hFF, 8'hFF, 4'b1000);

        // All four continuously valid: grants 0,1,2,3,0 every LAT+3 cycles
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, 8'((k + 1) * 7), 8'd1);
        end
        #1;
        for (int g = 0; g < 5; g++) begin
            push_exp(1'b0, IDW'(t3_ids[g]), t3_prod[t3_ids[g]]);
            wait_grant(80, n);
            check("t3_grant", 32'(req_ready), 32'd1 << t3_ids[g]);
            if (g > 0) begin
                check("t3_interval", n + 1, LAT + 3);
            end
            tick();
        end
        req_valid = '0;
        wait_rsp("t3_last_rsp", 80);
        tick();
        check("t3_idle", 32'(busy), 32'd0);

        // Backpressure: requester 1 served, requester 3 waits behind it
        rsp_ready = 1'b0;
        set_req(1, 8'hFD, 8'h04);
        set_req(3, 8'h7F, 8'h80);
        push_exp(1'b0, 2'd1, 16'hFFF4);
        push_exp(1'b0, 2'd3, 16'hC080);
        #1;
        check("t4_grant1", 32'(req_ready), 32'b0010);
        tick();
        drop_req(1);
        wait_rsp("t4_rsp", 80);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold", 32'({rsp_valid, rsp_err, rsp_id, rsp_product, busy}),
                  32'({1'b1, 1'b0, 2'd1, 16'hFFF4, 1'b1}));
            check("t4_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_no_grant_accept", 32'(req_ready), 32'd0);
        tick();
        check("t4_next_grant", 32'(req_ready), 32'b1000);
        tick();
        drop_req(3);
        wait_rsp("t4_rsp3", 80);
        tick();

        // Watchdog: core never answers
        core_hang = 1'b1;
        rstn_lows = 0;
        push_exp(1'b1, 2'd1, 16'h0000);
        set_req(1, 8'h09, 8'h09);
        #1;
        check("t5_grant", 32'(req_ready), 32'b0010);
        tick();
        drop_req(1);
        n = 0;
        while (mult_start && n < 40) begin
            if (!mult_rstn) rstn_lows++;
            n++;
            tick();
        end
        check("t5_run_cycles", n, TIMEOUT);
        check("t5_rstn_in_run", rstn_lows, 0);
        check("t5_abort", 32'({mult_rstn, mult_start, rsp_valid, state_dbg}), 32'({3'b000, 2'd3}));
        tick();
        check("t5_resp", 32'({mult_rstn, rsp_valid, rsp_err, rsp_product}),
              32'({1'b1, 1'b1, 1'b1, 16'h0000}));
        core_hang = 1'b0;
        tick();
        check("t5_idle", 32'(busy), 32'd0);
        push_exp(1'b0, 2'd0, 16'h000F);
        single_op("t5b", 0, 8'd3, 8'd5, 4'b0001);

        // Reset in the middle of RUN
        set_req(2, 8'h05, 8'h05);
        #1;
        check("t6_grant", 32'(req_ready), 32'b0100);
        tick();
        drop_req(2);
        repeat (5) tick();
        RSTn = 1'b0;
        #1;
        check("t6_rst_mult", 32'({mult_start, mult_a, mult_b, mult_rstn}), 32'd0);
        check("t6_rst_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_product, busy}), 32'd0);
        tick();
        tick();
        RSTn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
        end
        check("t6_no_rsp", 32'({rsp_valid, busy}), 32'd0);

        // Pointer back at 0: requester 0 beats requester 1
        set_req(0, 8'h10, 8'h10);
        set_req(1, 8'h7F, 8'h7F);
        push_exp(1'b0, 2'd0, 16'h0100);
        push_exp(1'b0, 2'd1, 16'h3F01);
        #1;
        check("t6_ptr_reset", 32'(req_ready), 32'b0001);
        tick();
        drop_req(0);
        wait_rsp("t6_rsp0", 80);
        tick();
        check("t6_grant1", 32'(req_ready), 32'b0010);
        tick();
        drop_req(1);
        wait_rsp("t6_rsp1", 80);
        tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("onehot0", 32'(multi_hot), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 signed Booth multiplier core between NREQ requesters.
- Latches the winning operands and drives the core's Start_Sig/A/B. Captures Product when the core signals done, then returns it to the granted requester with a valid/ready handshake.
- A watchdog aborts a hung operation and resets the core.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester index (ceil(log2(NREQ)), min 1)
- TIMEOUT, 32, cycles in RUN without mult_done before abort (core normally needs 19)

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_a  in  8*NREQ  multiplicand, requester k at [8k+7:8k], signed
- req_b  in  8*NREQ  multiplier, same packing, signed
- req_ready  out  NREQ  one-hot grant/accept, combinational, high only in IDLE
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  IDW  index of requester served
- rsp_product  out  16  signed product
- rsp_err  out  1  response is a timeout abort (product 0)
- mult_start  out  1  to core Start_Sig (registered)
- mult_a  out  8  to core A (registered operand latch)
- mult_b  out  8  to core B (registered operand latch)
- mult_done  in  1  from core Done_Sig (one-cycle pulse)
- mult_product  in  16  from core Product
- mult_rstn  out  1  to core RSTn = RSTn AND NOT abort_q
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, rr pointer 0, mult_start 0, mult_a/mult_b 0, rsp_valid 0, rsp_id 0, rsp_product 0, rsp_err 0, abort_q 0, watchdog 0.
- States: IDLE, RUN, RESP, ABORT.
- IDLE:
  - Winner = first k with req_valid[k], searching from rr pointer upward with wrap.
  - req_ready[winner]=1 in the same cycle; all other bits are 0.
  - On that edge: mult_a/mult_b <= winner's operands, id <= winner, mult_start <= 1, watchdog <= 0, go to RUN.
  - No req_valid: stay in IDLE, req_ready=0.
- RUN:
  - mult_start stays 1 and operands are held stable; watchdog increments each cycle.
  - mult_done=1: rsp_product <= mult_product, rsp_err <= 0, rsp_valid <= 1, mult_start <= 0, go to RESP.
  - Dropping start on that edge lets the core finish its done-clear step and park in its idle step.
  - watchdog == TIMEOUT-1 with no done: mult_start <= 0, abort_q <= 1, go to ABORT.
  - mult_done in the same cycle as the timeout: done wins.
- ABORT (1 cycle):
  - mult_rstn is low for exactly this cycle.
  - abort_q <= 0, rsp_valid <= 1, rsp_err <= 1, rsp_product <= 0, go to RESP.
- RESP:
  - rsp_valid/rsp_id/rsp_product/rsp_err held stable until rsp_ready=1.
  - On rsp_ready: rsp_valid <= 0, rr pointer <= id+1 (wrap at NREQ), go to IDLE.
  - A new grant is possible the cycle after acceptance.
- Requester protocol:
  - req_valid and operands must hold until req_ready.
  - Deasserting req_valid before grant withdraws the request, with no side effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
- Throughput: with rsp_ready tied 1, one operation per core latency + 3 cycles.
- Reset mid-operation returns everything to reset values asynchronously. The core is reset through mult_rstn, and no response is produced.
- Products are signed 16-bit two's complement. Operand -128 as multiplicand is unsupported by the core (its negation overflows); the arbiter passes it through unchanged.

Test Plan:
- Requester 0 only, a=3, b=5, rsp_ready=1 -> req_ready=4'b0001 for 1 cycle; mult_start high until done; rsp_valid with rsp_id=0, rsp_product=16'h000F, rsp_err=0; busy low afterwards.
- Requester 2, a=8'hFE (-2), b=3 -> rsp_product=16'hFFFA, rsp_id=2.
- All 4 valid continuously with distinct operands (k+1)*7 -> grant order 0,1,2,3,0. Each rsp_id matches, products 7,14,21,28, and req_ready is never multi-hot.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid -> rsp fields stable, no new grant, req_ready=0. Accept -> next grant follows the cycle after.
- Timeout: mult_done tied 0 -> after 32 RUN cycles mult_start=0, mult_rstn low exactly 1 cycle, rsp_err=1 with rsp_product=0, then normal operation 3*5=15 succeeds.
- RSTn pulsed low mid-RUN -> all outputs immediately at reset values, no rsp_valid. A subsequent request on requester 1 is granted first only if requester 0 is idle (pointer back to 0).
